shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, datapath width (only 32 supported; shamt width fixed at 5).
REQ-002 The block SHALL have port clock, input, 1, single clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port ctrl_shift, input, 1, start request, sampled each rising edge.
REQ-005 The block SHALL have port data_in, input, 32, operand, captured on an accepted start.
REQ-006 The block SHALL have port shamt, input, 5, shift amount, captured on an accepted start.
REQ-007 The block SHALL have port shift_type, input, 1, operation select: 0 = SLL, 1 = SRA; captured on an accepted start.
REQ-008 The block SHALL have port data_out, output, 32, result register.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port data_ready, output, 1, one-cycle pulse marking a valid result.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 A start SHALL be accepted on an edge where ctrl_shift=1 and the state is IDLE or DONE; the edge loads the working register with data_in, latches shamt and shift_type, and enters SHIFT.
REQ-013 ctrl_shift SHALL be ignored while in SHIFT; captured operands SHALL NOT change until the operation completes.
REQ-014 In SHIFT, each edge SHALL process one stage k, from 4 down to 0. The stage shifts the working register by 2^k when shamt[k]=1 and passes it unchanged otherwise.
REQ-015 SLL stages SHALL zero-fill the vacated low bits; SRA stages SHALL fill the vacated high bits with bit 31 of the working register.
REQ-016 After the final stage, the FSM SHALL enter DONE. DONE lasts exactly one cycle, with data_ready=1 and data_out equal to the result.
REQ-017 From DONE, the FSM SHALL go to IDLE, or to SHIFT if a start is accepted on the same edge.
REQ-018 data_out SHALL hold the last result until the next DONE; it SHALL NOT change during SHIFT.
REQ-019 busy SHALL be 1 in SHIFT only.
REQ-020 Latency SHALL be 5 edges from the load edge to DONE when the skip feature (REQ-025) is absent.

Reset
REQ-021 Reset SHALL force state IDLE, data_out=0, busy=0, data_ready=0, and clear the working registers.
REQ-022 Reset asserted mid-operation SHALL abort the operation, with no data_ready pulse.
REQ-023 Reset SHALL take priority over ctrl_shift on the same edge.
REQ-024 After reset deasserts, the first edge with ctrl_shift=1 SHALL be accepted.

Configuration
REQ-025 The macro SHIFT_SEQ_SKIP_EN SHALL control stage skipping.
- When defined, stages with shamt[k]=0 SHALL consume no cycle.
- Latency SHALL then be max(1, popcount(shamt)) edges from load to DONE.
- shamt=0 SHALL reach DONE one edge after load, with the result equal to data_in.
REQ-026 When SHIFT_SEQ_SKIP_EN is undefined, all five stages SHALL always execute, giving a fixed latency of 5.
REQ-027 Results SHALL be identical with and without SHIFT_SEQ_SKIP_EN.

Structure
REQ-028 The FSM state encodings and the SLL/SRA shift_type constants SHALL reside in shared package shift_seq_pkg, reused by the ALU decode.
REQ-029 The single variable-stage shifter SHALL be sub-module shift_stage: inputs value, stage index, enable, type; combinational output.
REQ-030 shift_stage SHALL be built from existing mux_2_in_1 cells.

Verification
REQ-031 SLL: data_in=0x00000001, shamt=31 SHALL give data_out=0x80000000 with data_ready exactly 5 edges after load (macro off).
REQ-032 SRA: data_in=0x80000000, shamt=4 SHALL give 0xF8000000. SRA: 0x7FFFFFFF, shamt=31 SHALL give 0x00000000.
REQ-033 A start asserted during SHIFT with different operands SHALL be ignored; the first result is unaffected and exactly one data_ready pulse is observed.
REQ-034 Back-to-back starts: a start asserted in the DONE cycle SHALL be accepted, and the second result SHALL follow 5 edges later with no IDLE gap.
REQ-035 Reset asserted on the 3rd SHIFT edge SHALL give data_out=0, busy=0, and no data_ready; a subsequent start SHALL complete normally.
REQ-036 With SHIFT_SEQ_SKIP_EN defined:
- shamt=0x10 SHALL give DONE 1 edge after load.
- shamt=0 SHALL give DONE 1 edge after load, with data_out=data_in.
- shamt=0x1F SHALL give DONE 5 edges after load.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM states, SLL/SRA select codes,
// stage-index sizing and a stage-selection helper.
package shift_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGE_W = 3;

    // shift_type codes, also used by the ALU decode.
    localparam logic SHIFT_SLL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    // Index of the highest set bit in mask; 0 when mask is empty.
    function automatic logic [STAGE_W-1:0] msb_index(input logic [SHAMT_W-1:0] mask);
        logic [STAGE_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (mask[k]) idx = STAGE_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_2_in_1.sv
// Library 2:1 multiplexer cell: o_y = i_sel ? i_b : i_a.
module mux_2_in_1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/shift_stage.sv
// One variable stage of the sequencer: shifts i_value by 2^i_stage (SLL or SRA)
// when i_enable is set, otherwise passes it through. Purely combinational.
module shift_stage
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0]  i_value,
    input  logic [STAGE_W-1:0] i_stage,
    input  logic               i_enable,
    input  logic               i_type,
    output logic [DATA_W-1:0]  o_value
);

    logic [DATA_W-1:0] w_cand [SHAMT_W];
    logic [DATA_W-1:0] w_l0_01;
    logic [DATA_W-1:0] w_l0_23;
    logic [DATA_W-1:0] w_l1;
    logic [DATA_W-1:0] w_shifted;
    logic              w_is_sra;

    assign w_is_sra = (i_type == SHIFT_SRA);

    // Fixed-distance candidates for each stage, SLL or SRA chosen per candidate.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_cand
        localparam int SH = 1 << k;
        logic [DATA_W-1:0] w_sll;
        logic [DATA_W-1:0] w_sra;

        assign w_sll = {i_value[DATA_W-1-SH:0], {SH{1'b0}}};
        assign w_sra = {{SH{i_value[DATA_W-1]}}, i_value[DATA_W-1:SH]};

        mux_2_in_1 #(.WIDTH(DATA_W)) u_type_mux (
            .i_a  (w_sll),
            .i_b  (w_sra),
            .i_sel(w_is_sra),
            .o_y  (w_cand[k])
        );
    end

    mux_2_in_1 #(.WIDTH(DATA_W)) u_sel_01 (
        .i_a(w_cand[0]), .i_b(w_cand[1]), .i_sel(i_stage[0]), .o_y(w_l0_01)
    );
    mux_2_in_1 #(.WIDTH(DATA_W)) u_sel_23 (
        .i_a(w_cand[2]), .i_b(w_cand[3]), .i_sel(i_stage[0]), .o_y(w_l0_23)
    );
    mux_2_in_1 #(.WIDTH(DATA_W)) u_sel_03 (
        .i_a(w_l0_01), .i_b(w_l0_23), .i_sel(i_stage[1]), .o_y(w_l1)
    );
    mux_2_in_1 #(.WIDTH(DATA_W)) u_sel_04 (
        .i_a(w_l1), .i_b(w_cand[4]), .i_sel(i_stage[2]), .o_y(w_shifted)
    );
    mux_2_in_1 #(.WIDTH(DATA_W)) u_enable (
        .i_a(i_value), .i_b(w_shifted), .i_sel(i_enable), .o_y(o_value)
    );

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter (SLL/SRA), one power-of-two stage per clock.
// Define SHIFT_SEQ_SKIP_EN to skip stages whose shamt bit is clear.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_shift,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic                  shift_type,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  data_ready
);

    seq_state_e            r_state;
    seq_state_e            w_state_next;
    logic [DATA_WIDTH-1:0] r_work;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] w_stage_out;
    logic [SHAMT_W-1:0]    r_shamt;
    logic [SHAMT_W-1:0]    w_stage_onehot;
    logic [STAGE_W-1:0]    r_stage;
    logic [STAGE_W-1:0]    w_first_stage;
    logic [STAGE_W-1:0]    w_next_stage;
    logic                  r_type;
    logic                  w_start;
    logic                  w_last;
    logic                  w_enable;

    // Starts are only honoured outside SHIFT so captured operands stay stable.
    assign w_start        = ctrl_shift && (r_state != SHIFT);
    assign w_stage_onehot = SHAMT_W'(1) << r_stage;
    assign w_enable       = |(r_shamt & w_stage_onehot);

`ifdef SHIFT_SEQ_SKIP_EN
    logic [SHAMT_W-1:0] w_remaining;

    assign w_remaining   = r_shamt & (w_stage_onehot - SHAMT_W'(1));
    assign w_last        = (w_remaining == '0);
    assign w_first_stage = msb_index(shamt);
    assign w_next_stage  = msb_index(w_remaining);
`else
    assign w_last        = (r_stage == '0);
    assign w_first_stage = STAGE_W'(SHAMT_W - 1);
    assign w_next_stage  = r_stage - STAGE_W'(1);
`endif

    shift_stage u_stage (
        .i_value (r_work),
        .i_stage (r_stage),
        .i_enable(w_enable),
        .i_type  (r_type),
        .o_value (w_stage_out)
    );

    // NOTE: every output is given a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        data_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                data_ready   = 1'b1;
                w_state_next = w_start ? SHIFT : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_data_out <= '0;
            r_shamt    <= '0;
            r_stage    <= '0;
            r_type     <= SHIFT_SLL;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_work  <= data_in;
                r_shamt <= shamt;
                r_type  <= shift_type;
                r_stage <= w_first_stage;
            end else if (r_state == SHIFT) begin
                r_work  <= w_stage_out;
                r_stage <= w_next_stage;
                if (w_last) r_data_out <= w_stage_out;
            end
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_shift;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        shift_type;
    logic [31:0] data_out;
    logic        busy;
    logic        data_ready;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_out;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        t;
    } vec_t;

    always #5 clock = ~clock;

    shift_sequencer #(.DATA_WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .ctrl_shift(ctrl_shift),
        .data_in   (data_in),
        .shamt     (shamt),
        .shift_type(shift_type),
        .data_out  (data_out),
        .busy      (busy),
        .data_ready(data_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [4:0] s,
                                               input logic t);
        if (t) return 32'($signed(d) >>> s);
        return d << s;
    endfunction

    function automatic int ref_latency(input logic [4:0] s);
`ifdef SHIFT_SEQ_SKIP_EN
        int c;
        c = $countones(s);
        return (c == 0) ? 1 : c;
`else
        return 5;
`endif
    endfunction

    // Drives a start for one edge (the load edge), then scrambles the inputs.
    task automatic start_op(input logic [31:0] d, input logic [4:0] s, input logic t);
        ctrl_shift = 1'b1;
        data_in    = d;
        shamt      = s;
        shift_type = t;
        step();
        ctrl_shift = 1'b0;
        data_in    = 32'($urandom);
        shamt      = 5'($urandom);
        shift_type = 1'($urandom);
    endtask

    // Runs from just after the load edge until the DONE cycle (bounded).
    task automatic wait_done(input string tag, input logic [31:0] d, input logic [4:0] s,
                             input logic t, input bit poke);
        logic [31:0] exp;
        int          lat;
        bit          done;
        exp  = ref_result(d, s, t);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold"}, data_out, model_out);
            if (poke && lat == 1) begin
                ctrl_shift = 1'b1;
                data_in    = ~d;
                shamt      = ~s;
                shift_type = ~t;
            end else begin
                ctrl_shift = 1'b0;
            end
            step();
            lat++;
            if (data_ready) done = 1'b1;
        end
        ctrl_shift = 1'b0;
        check({tag, "_timeout"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(s)));
        check({tag, "_result"}, data_out, exp);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        model_out = exp;
    endtask

    task automatic finish_idle(input string tag);
        step();
        check({tag, "_ready_low"}, 32'(data_ready), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_keep"}, data_out, model_out);
    endtask

    initial begin
        vec_t dirs [6];
        dirs = '{
            '{32'h0000_0001, 5'd31,   1'b0},
            '{32'h8000_0000, 5'd4,    1'b1},
            '{32'h7FFF_FFFF, 5'd31,   1'b1},
            '{32'h1234_5678, 5'h10,   1'b0},
            '{32'hA5A5_A5A5, 5'd0,    1'b1},
            '{32'hCAFE_F00D, 5'h1F,   1'b0}
        };

        // Reset wins over a simultaneous start.
        model_out  = '0;
        reset      = 1'b1;
        ctrl_shift = 1'b1;
        data_in    = 32'hDEAD_BEEF;
        shamt      = 5'd5;
        shift_type = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_dout", data_out, 32'd0);
        reset      = 1'b0;
        ctrl_shift = 1'b0;
        step();
        check("idle_ready", 32'(data_ready), 32'd0);

        // Directed corner cases; known constants cross-check the model.
        check("ref_sll31", ref_result(32'h1, 5'd31, 1'b0), 32'h8000_0000);
        check("ref_sra4", ref_result(32'h8000_0000, 5'd4, 1'b1), 32'hF800_0000);
        check("ref_sra31", ref_result(32'h7FFF_FFFF, 5'd31, 1'b1), 32'h0000_0000);
        for (int i = 0; i < 6; i++) begin
            start_op(dirs[i].d, dirs[i].s, dirs[i].t);
            wait_done($sformatf("dir%0d", i), dirs[i].d, dirs[i].s, dirs[i].t, 1'b0);
            finish_idle($sformatf("dir%0d", i));
        end

        // Start during SHIFT with different operands is ignored.
        start_op(32'h8765_4321, 5'b10110, 1'b1);
        wait_done("poke", 32'h8765_4321, 5'b10110, 1'b1, 1'b1);
        finish_idle("poke");

        // Back-to-back: second start in the DONE cycle.
        start_op(32'h0F0F_0F0F, 5'b00111, 1'b0);
        wait_done("b2b_a", 32'h0F0F_0F0F, 5'b00111, 1'b0, 1'b0);
        start_op(32'hF000_00F1, 5'b11001, 1'b1);
        wait_done("b2b_b", 32'hF000_00F1, 5'b11001, 1'b1, 1'b0);
        finish_idle("b2b");

        // Reset on the third SHIFT edge aborts the operation.
        start_op(32'h1357_9BDF, 5'h1F, 1'b0);
        step();
        step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        model_out = '0;
        check("abort_dout", data_out, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(data_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_ready", 32'(data_ready), 32'd0);
        end
        start_op(32'hFEDC_BA98, 5'd9, 1'b1);
        wait_done("post_abort", 32'hFEDC_BA98, 5'd9, 1'b1, 1'b0);
        finish_idle("post_abort");

        // Random operations, randomly chained back-to-back or separated by IDLE.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic        t;
            d = 32'($urandom);
            s = 5'($urandom);
            t = 1'($urandom);
            start_op(d, s, t);
            wait_done($sformatf("rnd%0d", i), d, s, t, 1'b0);
            if ($urandom_range(1) == 1) finish_idle($sformatf("rnd%0d", i));
        end
        finish_idle("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
